// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// Define MC_JUMP_EN to add the JUMP state for opcode 000010.
package mc_pkg;

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StFetch    = 4'd1,
      StDecode   = 4'd2,
      StMemAddr  = 4'd3,
      StMemRead  = 4'd4,
      StMemWb    = 4'd5,
      StMemWrite = 4'd6,
      StExecute  = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
`ifdef MC_JUMP_EN
      StJump     = 4'd10,
`endif
      StError    = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B        = 2'b00;
   localparam logic [1:0] SRCB_FOUR     = 2'b01;
   localparam logic [1:0] SRCB_IMM      = 2'b10;
   localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; timeout fires on the MEM_TIMEOUT-th one.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   output logic timeout
);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = waiting ? count_q + 8'd1 : 8'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= 8'd0;
      else     count_q <= count_d;
   end

   // count_q holds prior wait cycles, so this cycle is wait number count_q + 1
   assign timeout = waiting && (count_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-memory multi-cycle MIPS datapath.
// Define MC_JUMP_EN to support j (opcode 000010); otherwise it is illegal.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             error,
   output logic [1:0]       err_cause,
   output logic [CNT_W-1:0] instr_count
);

   state_e           state_q, state_d;
   logic [5:0]       op_q;
   logic             error_q;
   logic [1:0]       cause_q, fault_cause;
   logic [CNT_W-1:0] count_q;
   logic             waiting, timeout, retire;

   assign waiting = ((state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite))
                    && !mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .waiting (waiting),
      .timeout (timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         op_q    <= 6'd0;
         error_q <= 1'b0;
         cause_q <= ERR_NONE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StDecode) op_q <= opcode;
         if (!error_q && state_d == StError) begin
            error_q <= 1'b1;
            cause_q <= fault_cause;
         end
         if (retire) count_q <= count_q + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      fault_cause = ERR_TIMEOUT;
      unique case (state_q)
         StIdle:     state_d = StFetch;
         StFetch:    if (mem_ready) state_d = StDecode;
                     else if (timeout) state_d = StError;
         StDecode: begin
            fault_cause = ERR_ILLEGAL;
            case (opcode)
               OP_RTYPE:     state_d = StExecute;
               OP_LW, OP_SW: state_d = StMemAddr;
               OP_BEQ:       state_d = StBranch;
`ifdef MC_JUMP_EN
               OP_J:         state_d = StJump;
`endif
               default:      state_d = StError;
            endcase
         end
         StMemAddr:  state_d = (op_q == OP_SW) ? StMemWrite : StMemRead;
         StMemRead:  if (mem_ready) state_d = StMemWb;
                     else if (timeout) state_d = StError;
         StMemWb:    state_d = StFetch;
         StMemWrite: if (mem_ready) state_d = StFetch;
                     else if (timeout) state_d = StError;
         StExecute:  state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StBranch:   state_d = StFetch;
`ifdef MC_JUMP_EN
         StJump:     state_d = StFetch;
`endif
         StError:    state_d = StError;
         default:    state_d = StIdle;
      endcase
   end

   // Only the final state of an instruction ever moves into FETCH
   assign retire = (state_d == StFetch) && (state_q != StFetch) && (state_q != StIdle);

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      unique case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         StDecode:   alu_src_b = SRCB_IMM_SHL2;
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         StMemRead: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         StMemWrite: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         StExecute: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         StAluWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         StBranch: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
`ifdef MC_JUMP_EN
         StJump: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
`endif
         default: ;
      endcase
   end

   assign error       = error_q;
   assign err_cause   = cause_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: vector table, directed corner cases and random instruction stream.
module tb_multicycle_controller;

   localparam int unsigned TMO     = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_MOD = 1 << CNT_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [5:0]       opcode = 6'd0;
   logic             mem_ready = 1'b1;
   logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]       alu_src_b, alu_op, pc_source, err_cause;
   logic             error;
   logic [CNT_W-1:0] instr_count;
   logic [15:0]      ctl;

   multicycle_controller #(
      .MEM_TIMEOUT(TMO),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .error         (error),
      .err_cause     (err_cause),
      .instr_count   (instr_count)
   );

   always #5 clk = ~clk;

   assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

   function automatic logic [15:0] cw(input logic pcw, input logic pcc, input logic io,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic m2r, input logic rd, input logic rw,
                                      input logic sa, input logic [1:0] sb,
                                      input logic [1:0] aop, input logic [1:0] ps);
      return {pcw, pcc, io, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps};
   endfunction

   // Expected control words, written straight from the per-state output list
   logic [15:0] w_fetch, w_fetch_rdy, w_decode, w_addr, w_memrd, w_memwb, w_memwr;
   logic [15:0] w_exec, w_aluwb, w_branch, w_jump;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic m_err;
   logic [1:0] m_cause;
   int   m_cnt;
   bit   rand_mode = 1'b0;
   bit   ready_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic next_ready();
      if (rand_mode) return ($urandom_range(0, 3) != 0);
      if (ready_q.size() > 0) return ready_q.pop_front();
      return 1'b1;
   endfunction

   // Drive one cycle's inputs and compare every output against the model
   task automatic step(input logic rdy, input logic [5:0] op, input logic [15:0] exp,
                       input string name);
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = rdy;
      opcode    = op;
      #1;
      check(name, {9'd0, error, err_cause, 4'(instr_count), ctl},
            {9'd0, m_err, m_cause, 4'(m_cnt), exp});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      m_err = 1'b0;
      m_cause = 2'b00;
      m_cnt = 0;
      ready_q.delete();
      step(1'b1, 6'($urandom), 16'd0, "idle");
   endtask

   task automatic hold_error();
      for (int i = 0; i < 2; i++)
         step(1'($urandom), 6'($urandom), 16'd0, "error_hold");
   endtask

   task automatic mem_phase(input logic [15:0] base, input logic [15:0] extra,
                            input string name, inout int cycles, output logic to);
      int   waits = 0;
      logic r;
      to = 1'b0;
      forever begin
         r = next_ready();
         step(r, 6'($urandom), r ? (base | extra) : base, name);
         cycles++;
         if (r) return;
         waits++;
         if (waits == TMO) begin
            to = 1'b1;
            m_err = 1'b1;
            m_cause = 2'b10;
            return;
         end
      end
   endtask

   task automatic run_instr(input logic [5:0] op, output int cycles, output logic errd);
      logic to;
      cycles = 0;
      errd = 1'b0;
      mem_phase(w_fetch, w_fetch_rdy, "fetch", cycles, to);
      if (to) begin hold_error(); errd = 1'b1; return; end
      step(1'($urandom), op, w_decode, "decode");
      cycles++;
      case (op)
         6'b000000: begin
            step(1'($urandom), 6'($urandom), w_exec, "execute");
            step(1'($urandom), 6'($urandom), w_aluwb, "alu_wb");
            cycles += 2;
         end
         6'b100011: begin
            step(1'($urandom), 6'($urandom), w_addr, "mem_addr_lw");
            cycles++;
            mem_phase(w_memrd, 16'd0, "mem_read", cycles, to);
            if (to) begin hold_error(); errd = 1'b1; return; end
            step(1'($urandom), 6'($urandom), w_memwb, "mem_wb");
            cycles++;
         end
         6'b101011: begin
            step(1'($urandom), 6'($urandom), w_addr, "mem_addr_sw");
            cycles++;
            mem_phase(w_memwr, 16'd0, "mem_write", cycles, to);
            if (to) begin hold_error(); errd = 1'b1; return; end
         end
         6'b000100: begin
            step(1'($urandom), 6'($urandom), w_branch, "branch");
            cycles++;
         end
`ifdef MC_JUMP_EN
         6'b000010: begin
            step(1'($urandom), 6'($urandom), w_jump, "jump");
            cycles++;
         end
`endif
         default: begin
            m_err = 1'b1;
            m_cause = 2'b01;
            hold_error();
            errd = 1'b1;
            return;
         end
      endcase
      m_cnt = (m_cnt + 1) % CNT_MOD;
   endtask

   typedef struct {
      logic [5:0] op;
      int         fetch_waits;
      int         mem_waits;
      int         exp_cycles;
      logic [1:0] exp_cause;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc;
      logic errd;
      logic [5:0] op;
      w_fetch     = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      w_fetch_rdy = cw(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      w_decode    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      w_addr      = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      w_memrd     = cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      w_memwb     = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      w_memwr     = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      w_exec      = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
      w_aluwb     = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
      w_branch    = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
      w_jump      = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);

      //        op         fw mw cyc cause
      vecs.push_back('{6'b000000, 0, 0, 4, 2'b00});
      vecs.push_back('{6'b100011, 0, 3, 8, 2'b00});
      vecs.push_back('{6'b101011, 0, 0, 4, 2'b00});
      vecs.push_back('{6'b000100, 0, 0, 3, 2'b00});
`ifdef MC_JUMP_EN
      vecs.push_back('{6'b000010, 0, 0, 3, 2'b00});
`else
      vecs.push_back('{6'b000010, 0, 0, 2, 2'b01});
`endif
      vecs.push_back('{6'b111111, 0, 0, 2, 2'b01});
      vecs.push_back('{6'b000000, 4, 0, 4, 2'b10});
      vecs.push_back('{6'b000000, 3, 0, 7, 2'b00});
      vecs.push_back('{6'b100011, 0, 4, 7, 2'b10});
      vecs.push_back('{6'b101011, 0, 3, 7, 2'b00});
      vecs.push_back('{6'b100011, 2, 1, 8, 2'b00});

      foreach (vecs[i]) begin
         do_reset();
         for (int k = 0; k < vecs[i].fetch_waits; k++) ready_q.push_back(1'b0);
         ready_q.push_back(1'b1);
         for (int k = 0; k < vecs[i].mem_waits; k++) ready_q.push_back(1'b0);
         ready_q.push_back(1'b1);
         run_instr(vecs[i].op, cyc, errd);
         check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_error", i), {29'd0, error, err_cause},
               {29'd0, vecs[i].exp_cause != 2'b00, vecs[i].exp_cause});
         check($sformatf("vec%0d_count", i), 32'(instr_count),
               (vecs[i].exp_cause == 2'b00) ? 32'd1 : 32'd0);
      end

      // beq followed by sw without reset
      do_reset();
      run_instr(6'b000100, cyc, errd);
      check("beq_cycles", 32'(cyc), 32'd3);
      run_instr(6'b101011, cyc, errd);
      check("sw_cycles", 32'(cyc), 32'd4);
      @(posedge clk);
      #1;
      check("beq_sw_count", 32'(instr_count), 32'd2);

      // reset after an error clears the sticky flag
      do_reset();
      run_instr(6'b111110, cyc, errd);
      do_reset();
      check("post_reset_error", {30'd0, error, 1'b0}, 32'd0);

      // random stream; count wraps several times at CNT_W = 4
      rand_mode = 1'b1;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    op = 6'b000000;
            2, 3:    op = 6'b100011;
            4, 5:    op = 6'b101011;
            6, 7:    op = 6'b000100;
            8:       op = 6'b000010;
            default: op = 6'($urandom);
         endcase
         run_instr(op, cyc, errd);
         if (errd) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
